// File: rtl/logic_op_stream.sv
// logic_op_stream: two-stage valid/ready bitwise logic pipeline with result flags and transfer counter
module logic_op_stream #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_parity,
    output logic [COUNT_W-1:0] xfer_count
);
    logic               v1_q, v2_q, zero2_q, par2_q, adv1, adv2;
    logic [WIDTH-1:0]   a1_q, b1_q, y2_q, y_d;
    logic [2:0]         op1_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    assign adv2       = !v2_q || out_ready;
    assign adv1       = !v1_q || adv2;
    assign in_ready   = adv1 || rst;
    assign out_valid  = v2_q;
    assign out_y      = y2_q;
    assign out_zero   = zero2_q;
    assign out_parity = par2_q;
    assign xfer_count = cnt_q;
    assign cnt_d      = (v2_q && out_ready) ? cnt_q + COUNT_W'(1) : cnt_q;
    always_comb begin
        y_d = a1_q;
        case (op1_q)
            3'd0: y_d = a1_q & b1_q;
            3'd1: y_d = a1_q | b1_q;
            3'd2: y_d = a1_q ^ b1_q;
            3'd3: y_d = ~(a1_q & b1_q);
            3'd4: y_d = ~(a1_q | b1_q);
            3'd5: y_d = ~(a1_q ^ b1_q);
            3'd6: y_d = a1_q & ~b1_q;
            default: y_d = a1_q;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            op1_q   <= '0;
            y2_q    <= '0;
            zero2_q <= 1'b0;
            par2_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    y2_q    <= y_d;
                    zero2_q <= (y_d == '0);
                    par2_q  <= ^y_d;
                end
            end
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    a1_q  <= in_a;
                    b1_q  <= in_b;
                    op1_q <= in_op;
                end
            end
        end
    end
endmodule

// File: tb/tb_logic_op_stream.sv
// tb_logic_op_stream: directed vectors against a 4-bit and an 8-bit (3-bit counter) instance
module tb_logic_op_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v4 = 1'b0, rdy4, ov4, or4 = 1'b1, z4, p4;
    logic [3:0]  a4 = '0, b4 = '0, y4;
    logic [2:0]  op4 = '0;
    logic [15:0] c4;

    logic        iv = 1'b0, ir, ov, ordy = 1'b1, oz, op_par;
    logic [7:0]  ia = '0, ib = '0, oy;
    logic [2:0]  iop = '0;
    logic [2:0]  cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sweep_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
    logic [7:0] bp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    logic_op_stream #(.WIDTH(4), .COUNT_W(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4), .in_op(op4),
        .out_valid(ov4), .out_ready(or4), .out_y(y4), .out_zero(z4), .out_parity(p4), .xfer_count(c4)
    );

    logic_op_stream #(.WIDTH(8), .COUNT_W(3)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_op(iop),
        .out_valid(ov), .out_ready(ordy), .out_y(oy), .out_zero(oz), .out_parity(op_par), .xfer_count(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, got_n;
        logic acc, outv;
        logic [7:0] outy;
        tick;
        tick;
        chk("rst_ready4", rdy4, 1);
        chk("rst_valid8", ov, 0);
        chk("rst_y8", oy, 0);
        chk("rst_cnt8", cnt, 0);
        rst = 1'b0;

        // single 4-bit beat: result two cycles after input transfer
        v4 = 1'b1; a4 = 4'b0100; b4 = 4'b1100; op4 = 3'd0;
        tick;
        v4 = 1'b0;
        chk("lat_early", ov4, 0);
        tick;
        chk("lat_valid", ov4, 1);
        chk("lat_y", y4, 4'b0100);
        chk("lat_zero", z4, 0);
        chk("lat_par", p4, 1);
        tick;
        chk("lat_cnt", c4, 1);
        chk("lat_drain", ov4, 0);

        // opcode sweep back-to-back
        ia = 8'hF0; ib = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            iv = (i < 8);
            iop = 3'(i);
            #1;
            chk("sweep_ready", ir, 1);
            tick;
            if (i >= 1 && i <= 8) begin
                chk("sweep_valid", ov, 1);
                chk($sformatf("sweep_y%0d", i - 1), oy, sweep_exp[i - 1]);
            end
        end
        iv = 1'b0;
        chk("sweep_cnt_wrap", cnt, 0);
        chk("sweep_drain", ov, 0);

        // zero and parity flags
        iv = 1'b1; iop = 3'd2; ia = 8'hA5; ib = 8'hA5;
        tick;
        iop = 3'd7; ia = 8'h01; ib = 8'h00;
        tick;
        iv = 1'b0;
        chk("zp_y0", oy, 0);
        chk("zp_zero0", oz, 1);
        chk("zp_par0", op_par, 0);
        tick;
        chk("wrap_cnt9", cnt, 1);
        chk("zp_y1", oy, 8'h01);
        chk("zp_zero1", oz, 0);
        chk("zp_par1", op_par, 1);
        tick;
        chk("zp_cnt", cnt, 2);

        // backpressure: only two beats fit while the sink stalls
        ordy = 1'b0; iop = 3'd7; ib = 8'h00; k = 0;
        for (int c = 0; c < 4; c++) begin
            iv = 1'b1;
            ia = bp[k];
            #1;
            chk("bp_ready", ir, (c < 2) ? 1 : 0);
            acc = ir;
            tick;
            if (acc) k++;
            if (c >= 1) chk("bp_hold_y", oy, 8'h11);
        end
        chk("bp_accepted", k, 2);
        ordy = 1'b1; got_n = 0;
        for (int c = 0; c < 8; c++) begin
            iv = (k < 4);
            ia = (k < 4) ? bp[k] : 8'h00;
            #1;
            acc = iv && ir;
            outv = ov;
            outy = oy;
            tick;
            if (acc) k++;
            if (outv) begin
                chk("bp_order", outy, (got_n < 4) ? bp[got_n] : 8'hXX);
                got_n++;
            end
        end
        iv = 1'b0;
        chk("bp_count_out", got_n, 4);
        chk("bp_cnt", cnt, 6);

        // reset mid-stream discards in-flight beats
        ordy = 1'b0; iv = 1'b1; ia = 8'h55;
        tick;
        ia = 8'h66;
        tick;
        chk("mid_valid", ov, 1);
        rst = 1'b1; ia = 8'h99;
        #1;
        chk("mid_rst_ready", ir, 1);
        tick;
        rst = 1'b0; iv = 1'b0; ordy = 1'b1;
        chk("mid_valid0", ov, 0);
        chk("mid_cnt0", cnt, 0);
        chk("mid_y0", oy, 0);
        chk("mid_zero0", oz, 0);
        chk("mid_par0", op_par, 0);
        tick;
        chk("mid_no_ghost1", ov, 0);
        tick;
        chk("mid_no_ghost2", ov, 0);
        iv = 1'b1; ia = 8'h77;
        tick;
        iv = 1'b0;
        chk("mid_new_early", ov, 0);
        tick;
        chk("mid_new_valid", ov, 1);
        chk("mid_new_y", oy, 8'h77);
        tick;
        chk("mid_new_done", ov, 0);
        chk("mid_new_cnt", cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
